display_scan_counter: RTL
=========================

# display_scan_counter

Parametrised digit-scan controller for the multiplexed seven-segment display. It runs on the system clock and derives its own digit-slot timing from an internal prescaler, so no separate slow refresh clock is needed. It cycles a digit index over any count of digits, not only powers of two, and drives active-low anode selects with per-digit blanking. It also emits slot and frame pulses for the digit-data mux and any frame-synchronous logic.

## Interface
- NUM_DIGITS, 4, number of multiplexed digits; legal range 2..16.
- PRESCALE, 100000, clock cycles per digit slot; legal range 1..2^24.
- Derived IDX_W = max(1, clog2(NUM_DIGITS)); PS_W = max(1, clog2(PRESCALE)).
- clock  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high; overrides every other input.
- enable  in  1  1 = scanning; 0 = freeze prescaler and index, blank all anodes.
- digitMask  in  NUM_DIGITS  bit i = 1 lights digit i in its slot; 0 blanks it (slot time still consumed).
- digitIndex  out  IDX_W  registered current digit, 0..NUM_DIGITS-1.
- anode  out  NUM_DIGITS  active-low one-hot digit select.
- digitTick  out  1  registered one-cycle pulse, high in the first cycle of each new slot.
- frameTick  out  1  registered one-cycle pulse, high in the first cycle of slot 0 after a wrap.

## Operation
- Prescaler psCount (PS_W bits) counts 0..PRESCALE-1 on enabled cycles.
- At terminal count (psCount == PRESCALE-1 with enable = 1), the next edge does the following:
  - psCount becomes 0.
  - digitIndex advances by one.
  - digitTick becomes 1.
- Index wrap: digitIndex == NUM_DIGITS-1 advances to 0, and frameTick is set together with digitTick. The index never takes values >= NUM_DIGITS.
- Unlisted edges: digitTick and frameTick are 0 on every edge not listed above.
- enable = 0: psCount and digitIndex hold their values and both ticks are 0. Scanning resumes at the held psCount with no slot restart.
- anode is combinational from registered digitIndex, digitMask, enable and reset:
  - anode[i] = 0 only if i == digitIndex, digitMask[i] = 1, enable = 1 and reset = 0.
  - Otherwise anode[i] = 1.
- digitMask changes take effect in the same cycle. They never alter slot timing.
- PRESCALE = 1: the index advances on every enabled edge and digitTick stays high continuously while enabled.

## Timing
- Reset values, following any edge with reset = 1:
  - psCount = 0, digitIndex = 0, digitTick = 0, frameTick = 0.
  - anode = all ones while reset is high.
- Reset mid-slot or mid-frame: clears on the next edge and discards the partial slot. The first post-reset slot is a full PRESCALE enabled cycles.
- Slot length: exactly PRESCALE enabled cycles. Frame length: NUM_DIGITS × PRESCALE enabled cycles.
- Latency: digitIndex, digitTick and frameTick change on the same edge. anode follows digitIndex with zero added cycles.
- Simultaneous enable falling and terminal count: with enable = 0 on the terminal cycle, there is no advance and no tick. The advance happens on the first enabled edge afterwards.
- Simultaneous reset and terminal count: reset wins; the index goes to 0 and no ticks are emitted.

## Test plan
- NUM_DIGITS=3, PRESCALE=4, enable=1, mask=111, reset released at edge 0:
  - digitIndex reads 0,0,0,0,1,1,1,1,2,2,2,2,0.
  - digitTick is high at cycles 4, 8 and 12.
  - frameTick is high only at cycle 12.
  - anode reads 110, 101, 011 in turn.
- Same config, enable low for cycles 5..9: the index holds at 1 and no ticks occur. After resume, the remaining 3 slot cycles complete before the index reaches 2. anode = 111 while enable is low.
- Same config, mask=101: the slot-1 anode is 111 for its 4 cycles, while index and tick timing are unchanged versus the unmasked run.
- Reset asserted for 1 cycle at cycle 6 (index 1, psCount 2): the next cycle shows index 0 and psCount 0. The next digitTick comes 4 cycles after reset deasserts.
- NUM_DIGITS=5, PRESCALE=1: the index reads 0,1,2,3,4,0 on consecutive cycles, digitTick is constantly high, and frameTick pulses every 5th cycle. The index never reaches 5..7.
- NUM_DIGITS=4, PRESCALE=2, reset held high across a terminal-count cycle: no tick is emitted and the outputs stay at their reset values.

Source files
------------

// File: rtl/display_scan_counter.sv
// rtl/display_scan_counter.sv - prescaled digit-scan controller for a multiplexed seven-segment display
module display_scan_counter #(
  parameter int NUM_DIGITS = 4,
  parameter int PRESCALE   = 100000,
  localparam int IDX_W = ($clog2(NUM_DIGITS) > 1) ? $clog2(NUM_DIGITS) : 1,
  localparam int PS_W  = ($clog2(PRESCALE) > 1) ? $clog2(PRESCALE) : 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [NUM_DIGITS-1:0] digitMask,
  output logic [IDX_W-1:0]      digitIndex,
  output logic [NUM_DIGITS-1:0] anode,
  output logic                  digitTick,
  output logic                  frameTick
);

  localparam logic [PS_W-1:0]  PS_LAST  = PS_W'(PRESCALE - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  logic [PS_W-1:0] psCount;
  logic            slotEnd;
  logic            lastDigit;

  assign slotEnd   = enable && (psCount == PS_LAST);
  assign lastDigit = (digitIndex == IDX_LAST);

  always_ff @(posedge clock) begin
    if (reset) begin
      psCount    <= '0;
      digitIndex <= '0;
      digitTick  <= 1'b0;
      frameTick  <= 1'b0;
    end else begin
      digitTick <= slotEnd;
      frameTick <= slotEnd && lastDigit;
      if (slotEnd) begin
        psCount    <= '0;
        digitIndex <= lastDigit ? '0 : digitIndex + IDX_W'(1);
      end else if (enable) begin
        psCount <= psCount + PS_W'(1);
      end
    end
  end

  // Blanking is combinational so mask and enable changes show in the same cycle.
  always_comb begin
    anode = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (digitIndex == IDX_W'(i) && digitMask[i] && enable && !reset)
        anode[i] = 1'b0;
    end
  end

endmodule
